// File: rtl/debug_trace_buffer_if.sv
// rtl/debug_trace_buffer_if.sv - trace stream handshake bundle
// Purpose: carries the trace entry stream from the buffer to its consumer.
// Signals:
//   trace_vld_o  - head entry valid (driven by the buffer)
//   trace_rdy_i  - consumer ready (driven by the consumer)
//   trace_data_o - {flags[7:0], timestamp} of the head entry
// Modports: master = trace buffer side, slave = consumer side.
interface debug_trace_buffer_if;
    logic        trace_vld_o;
    logic        trace_rdy_i;
    logic [31:0] trace_data_o;

    modport master (
        output trace_vld_o,
        output trace_data_o,
        input  trace_rdy_i
    );

    modport slave (
        input  trace_vld_o,
        input  trace_data_o,
        output trace_rdy_i
    );
endinterface

// File: rtl/debug_trace_buffer.sv
// rtl/debug_trace_buffer.sv - handshake-flag change tracer with timestamped FIFO
// Purpose: while armed, records every change of the pipeline handshake flags
// (plus the first sample after arming) as {flags, timestamp} into a FIFO that
// the consumer drains through a valid/ready stream.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   flags_i      - {spmm_vld, spmm_rdy, dmvm_vld, dmvm_rdy, sm_vld, sm_rdy, aggr_vld, aggr_rdy}
//   arm_i        - level enable: high runs the tracer, low returns it to idle
//   cnt_o        - FIFO occupancy, 0..DEPTH
//   ovf_o        - sticky: a capture was dropped because the FIFO was full
//   running_o    - high while the tracer is in RUN
//   trace        - trace stream (master modport)
module debug_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int TS_W  = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             flags_i,
    input  logic                   arm_i,
    output logic [$clog2(DEPTH):0] cnt_o,
    output logic                   ovf_o,
    output logic                   running_o,
    debug_trace_buffer_if.master   trace
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          r_state;
    logic            r_first;
    logic            r_running;
    logic            r_ovf;
    logic [TS_W-1:0] r_ts;
    logic [7:0]      r_flags_prev;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_cnt;
    logic [31:0]     r_mem [DEPTH];

    logic              w_capture;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic [8+TS_W-1:0] w_entry_raw;
    logic [31:0]       w_entry;

    assign w_entry_raw = {flags_i, r_ts};
    assign w_entry     = 32'(w_entry_raw);

    // DEPTH is a power of two, so the occupancy MSB alone marks full.
    assign w_full    = r_cnt[AW];
    assign w_pop     = (r_cnt != '0) && trace.trace_rdy_i;
    assign w_capture = (r_state == S_RUN) && (r_first || (flags_i != r_flags_prev));
    // A full FIFO still accepts a capture when the head leaves on the same edge.
    assign w_push    = w_capture && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_first      <= 1'b0;
            r_running    <= 1'b0;
            r_ovf        <= 1'b0;
            r_ts         <= '0;
            r_flags_prev <= '0;
        end else begin
            r_flags_prev <= flags_i;
            case (r_state)
                S_IDLE: begin
                    if (arm_i) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                        r_first   <= 1'b1;
                        r_ts      <= '0;
                        r_ovf     <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_first <= 1'b0;
                    if (r_ts != '1) begin
                        r_ts <= r_ts + TS_W'(1);
                    end
                    if (w_capture && w_full && !w_pop) begin
                        r_ovf <= 1'b1;
                    end
                    if (!arm_i) begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    assign trace.trace_vld_o  = (r_cnt != '0);
    assign trace.trace_data_o = r_mem[r_rptr];
    assign cnt_o              = r_cnt;
    assign ovf_o              = r_ovf;
    assign running_o          = r_running;
endmodule
